// File: rtl/if_id_decode_reg.sv
// Purpose: IF/ID pipeline register for a MIPS CPU with combinational field decode.
// Latency: 1 cycle from in_* to out_* and every decoded field.
// Backpressure: stall holds the register and counts stalled-valid cycles; flush inserts a bubble.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/in_instr/in_pc   instruction presented by IF
//   stall, flush    hazard-unit hold and branch/jump bubble request (flush wins)
//   out_valid/out_instr/out_pc registered instruction and PC
//   op..imm16       raw MIPS fields of out_instr
//   imm_ext         zero-extended for ANDI/ORI/XORI, sign-extended otherwise
//   index, jtarget  J-format index and jump target computed from out_pc + 4
//   stall_cnt       saturating count of cycles spent stalled with a valid instruction
// Optional (macro DEC_CLASS_EN): is_rtype, is_jtype, is_load, is_store class flags.
//
// INSTR_W must be 32 (fields are fixed MIPS positions); PC_W must be >= 28.
module if_id_decode_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [5:0]         op,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm16,
    output logic [31:0]        imm_ext,
    output logic [31:0]        index,
    output logic [PC_W-1:0]    jtarget,
`ifdef DEC_CLASS_EN
    output logic               is_rtype,
    output logic               is_jtype,
    output logic               is_load,
    output logic               is_store,
`endif
    output logic [CNT_W-1:0]   stall_cnt
);

    // Keeps only the PC bits above the 28-bit jump region.
    localparam logic [PC_W-1:0] PC_HI_MASK = ~(PC_W'(28'hFFF_FFFF));

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q,    pc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [PC_W-1:0]    pc4;
    logic               imm_zext;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc_d    = '0;
        end else if (stall) begin
            // Only cycles holding a real instruction are hazard stalls worth counting.
            if (valid_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d = in_valid;
            instr_d = in_valid ? in_instr : '0;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign stall_cnt = cnt_q;

    assign op    = instr_q[31:26];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign rd    = instr_q[15:11];
    assign shamt = instr_q[10:6];
    assign funct = instr_q[5:0];
    assign imm16 = instr_q[15:0];

    // Logical immediates (ANDI/ORI/XORI) are zero-extended; everything else sign-extends.
    assign imm_zext = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    assign imm_ext  = imm_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

    assign index   = {6'b0, instr_q[25:0]};
    assign pc4     = pc_q + PC_W'(4);
    assign jtarget = (pc4 & PC_HI_MASK) | PC_W'({instr_q[25:0], 2'b00});

`ifdef DEC_CLASS_EN
    assign is_rtype = valid_q && (op == 6'h00);
    assign is_jtype = valid_q && ((op == 6'h02) || (op == 6'h03));
    assign is_load  = valid_q && (op >= 6'h20) && (op <= 6'h25);
    assign is_store = valid_q && (op >= 6'h28) && (op <= 6'h2B);
`endif

endmodule

// File: tb/tb_if_id_decode_reg.sv
module tb_if_id_decode_reg;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [31:0] in_instr, in_pc;

    logic        out_valid;
    logic [31:0] out_instr, out_pc, imm_ext, index, jtarget;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16, stall_cnt;

    logic        s_out_valid;
    logic [31:0] s_out_instr, s_out_pc, s_imm_ext, s_index, s_jtarget;
    logic [5:0]  s_op, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] s_imm16;
    logic [1:0]  s_stall_cnt;
`ifdef DEC_CLASS_EN
    logic is_rtype, is_jtype, is_load, is_store;
    logic s_is_rtype, s_is_jtype, s_is_load, s_is_store;
`endif

    always #5 clk = ~clk;

    if_id_decode_reg #(.INSTR_W(32), .PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm16(imm16), .imm_ext(imm_ext), .index(index), .jtarget(jtarget),
`ifdef DEC_CLASS_EN
        .is_rtype(is_rtype), .is_jtype(is_jtype), .is_load(is_load), .is_store(is_store),
`endif
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    if_id_decode_reg #(.INSTR_W(32), .PC_W(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .stall(stall), .flush(flush), .out_valid(s_out_valid), .out_instr(s_out_instr),
        .out_pc(s_out_pc), .op(s_op), .rs(s_rs), .rt(s_rt), .rd(s_rd), .shamt(s_shamt),
        .funct(s_funct), .imm16(s_imm16), .imm_ext(s_imm_ext), .index(s_index),
        .jtarget(s_jtarget),
`ifdef DEC_CLASS_EN
        .is_rtype(s_is_rtype), .is_jtype(s_is_jtype), .is_load(s_is_load), .is_store(s_is_store),
`endif
        .stall_cnt(s_stall_cnt)
    );

    int passed = 0;
    int total  = 0;

    // Reference state: what the IF/ID register should hold after each edge.
    int unsigned m_valid, m_instr, m_pc, m_cnt, m_cnt_s;

    logic [5:0] op_tab [10] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic st, input logic fl);
        @(negedge clk);
        rst = r; in_valid = v; in_instr = ins; in_pc = pc; stall = st; flush = fl;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_cnt = 0; m_cnt_s = 0;
        end else if (fl) begin
            m_valid = 0; m_instr = 0; m_pc = 0;
        end else if (st) begin
            if (m_valid != 0) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (m_cnt_s < 3) m_cnt_s = m_cnt_s + 1;
            end
        end else begin
            m_valid = v ? 1 : 0;
            m_pc    = pc;
            m_instr = v ? ins : 0;
        end
        #1;
    endtask

    task automatic check_all();
        int unsigned e_op, e_imm, e_ext;
        e_op  = m_instr / (2**26);
        e_imm = m_instr % 65536;
        if (e_op == 12 || e_op == 13 || e_op == 14) e_ext = e_imm;
        else if (e_imm >= 32768) e_ext = e_imm + 32'hFFFF_0000;
        else e_ext = e_imm;
        check("out_valid", 32'(out_valid), m_valid);
        check("out_instr", out_instr, m_instr);
        check("out_pc", out_pc, m_pc);
        check("op", 32'(op), e_op);
        check("rs", 32'(rs), (m_instr / (2**21)) % 32);
        check("rt", 32'(rt), (m_instr / (2**16)) % 32);
        check("rd", 32'(rd), (m_instr / (2**11)) % 32);
        check("shamt", 32'(shamt), (m_instr / 64) % 32);
        check("funct", 32'(funct), m_instr % 64);
        check("imm16", 32'(imm16), e_imm);
        check("imm_ext", imm_ext, e_ext);
        check("index", index, m_instr % (2**26));
        check("jtarget", jtarget, ((m_pc + 4) & 32'hF000_0000) | ((m_instr % (2**26)) * 4));
        check("stall_cnt", 32'(stall_cnt), m_cnt);
        check("stall_cnt_sat", 32'(s_stall_cnt), m_cnt_s);
`ifdef DEC_CLASS_EN
        check("is_rtype", 32'(is_rtype), (m_valid != 0 && e_op == 0) ? 1 : 0);
        check("is_jtype", 32'(is_jtype), (m_valid != 0 && (e_op == 2 || e_op == 3)) ? 1 : 0);
        check("is_load", 32'(is_load), (m_valid != 0 && e_op >= 32 && e_op <= 37) ? 1 : 0);
        check("is_store", 32'(is_store), (m_valid != 0 && e_op >= 40 && e_op <= 43) ? 1 : 0);
`endif
    endtask

    initial begin
        logic [31:0] ri;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; stall = 1'b0; flush = 1'b0;
        m_valid = 0; m_instr = 0; m_pc = 0; m_cnt = 0; m_cnt_s = 0;

        // Reset with a live instruction on the inputs.
        step(1, 1, 32'h2008FFFF, 32'h0040_0000, 0, 0);
        step(1, 1, 32'h2008FFFF, 32'h0040_0000, 0, 0);
        check_all();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_jtarget", jtarget, 32'h0);

        // ADDI: sign-extended immediate.
        step(0, 1, 32'h2008FFFF, 32'h0040_0000, 0, 0);
        check_all();
        check("addi_op", 32'(op), 32'h08);
        check("addi_rt", 32'(rt), 32'h8);
        check("addi_imm_ext", imm_ext, 32'hFFFF_FFFF);
        check("addi_pc", out_pc, 32'h0040_0000);

        // ORI: zero-extended immediate.
        step(0, 1, 32'h3508FFFF, 32'h0040_0004, 0, 0);
        check_all();
        check("ori_imm_ext", imm_ext, 32'h0000_FFFF);

        // J: jump target from pc+4 upper bits.
        step(0, 1, 32'h08000010, 32'h0040_0000, 0, 0);
        check_all();
        check("j_jtarget", jtarget, 32'h0000_0040);
        check("j_index", index, 32'h0000_0010);

        // Stall three cycles with junk inputs: contents hold, counter reaches 3.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, $urandom, $urandom, 1, 0);
            check_all();
            check("stall_hold", out_instr, 32'h08000010);
        end
        check("stall_cnt3", 32'(stall_cnt), 32'd3);

        // Stall+flush: flush wins, counter unchanged.
        step(0, 1, $urandom, $urandom, 1, 1);
        check_all();
        check("sf_valid", 32'(out_valid), 32'h0);
        check("sf_cnt", 32'(stall_cnt), 32'd3);

        // Stall on a bubble does not count.
        step(0, 1, 32'h1234_5678, 32'h10, 1, 0);
        check_all();
        check("bubble_stall_cnt", 32'(stall_cnt), 32'd3);

        // Saturation of the 2-bit counter over five stalled-valid cycles.
        step(0, 1, 32'h8C080004, 32'h0040_0100, 0, 0);
        check_all();
`ifdef DEC_CLASS_EN
        check("lw_is_load", 32'(is_load), 32'h1);
        check("lw_is_rtype", 32'(is_rtype), 32'h0);
`endif
        for (int i = 0; i < 5; i++) begin
            step(0, 0, $urandom, $urandom, 1, 0);
            check_all();
        end
        check("sat_cnt", 32'(s_stall_cnt), 32'd3);
        check("wide_cnt", 32'(stall_cnt), 32'd8);

        // Flush clears class flags.
        step(0, 1, 32'h8C080004, 32'h0, 0, 1);
        check_all();
`ifdef DEC_CLASS_EN
        check("flush_is_load", 32'(is_load), 32'h0);
`endif

        // in_valid=0 load: bubble, but PC still taken.
        step(0, 0, 32'hDEAD_BEEF, 32'h0040_0200, 0, 0);
        check_all();
        check("bubble_pc", out_pc, 32'h0040_0200);
        check("bubble_instr", out_instr, 32'h0);

        // Reset during stall clears the counter.
        step(0, 1, 32'h0109_5020, 32'h0040_0300, 0, 0);
        step(0, 1, 32'h0, 32'h0, 1, 0);
        step(1, 1, 32'h2008FFFF, 32'h0040_0000, 1, 1);
        check_all();
        check("rst_mid_stall_cnt", 32'(stall_cnt), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            ri = $urandom;
            ri[31:26] = ($urandom_range(0, 3) == 0) ? ri[31:26] : op_tab[$urandom_range(0, 9)];
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ri, $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
            check_all();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_decode_reg.md
Name: if_id_decode_reg

Overview:
- Parametrised successor of the combinational instruction-field decoder.
- Registers the fetched MIPS instruction and its PC at the IF/ID boundary of the pipelined CPU.
- Supports stall (hold) and flush (bubble insertion).
- Presents decoded fields, an extended immediate and a jump target to the ID stage.
- Keeps a saturating stall-cycle counter for hazard-unit debug.

Parameters:
- INSTR_W, 32, instruction width; fields are taken from bits [31:0], so it must be 32.
- PC_W, 32, PC width; must be >= 28.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  IF stage has a valid instruction this cycle
- in_instr  input  INSTR_W  fetched instruction
- in_pc  input  PC_W  PC of in_instr
- stall  input  1  hold the register contents (from the hazard unit)
- flush  input  1  replace the register contents with a bubble (branch/jump taken)
- out_valid  output  1  registered instruction is valid
- out_instr  output  INSTR_W  registered instruction
- out_pc  output  PC_W  registered PC
- op  output  6  out_instr[31:26]
- rs  output  5  out_instr[25:21]
- rt  output  5  out_instr[20:16]
- rd  output  5  out_instr[15:11]
- shamt  output  5  out_instr[10:6]
- funct  output  6  out_instr[5:0]
- imm16  output  16  out_instr[15:0]
- imm_ext  output  32  extended immediate
- index  output  32  {6'b0, out_instr[25:0]}
- jtarget  output  PC_W  jump target
- stall_cnt  output  CNT_W  saturating count of stalled-valid cycles

Behaviour:
- Reset (sync, rst=1 at posedge): out_valid=0, out_instr=0 (NOP), out_pc=0, stall_cnt=0. All decoded outputs therefore read 0, except imm_ext=0 and jtarget=0.
- Priority at each posedge: rst > flush > stall > load.
- Flush: out_valid<=0, out_instr<=0, out_pc<=0. Flush overrides a simultaneous stall.
- Stall (no flush): out_valid, out_instr and out_pc hold their values.
- Load (no stall, no flush): out_valid<=in_valid; out_pc<=in_pc; out_instr<=in_instr if in_valid, else 0.
- Latency: 1 cycle from in_* to out_* and to all decoded fields.
- Decoded fields are purely combinational from the out_instr/out_pc registers; no additional latency.
- imm_ext: zero-extended when op is 0x0C (ANDI), 0x0D (ORI) or 0x0E (XORI); otherwise sign-extended from imm16[15].
- jtarget = {pc4[PC_W-1:28], out_instr[25:0], 2'b00}, where pc4 = out_pc + 4 (modulo 2^PC_W).
- stall_cnt increments by 1 on each posedge where stall=1, flush=0, rst=0 and out_valid=1.
- stall_cnt saturates at 2^CNT_W-1; it never wraps.
- stall_cnt is cleared only by rst.
- Reset asserted mid-stall or mid-flush: reset values win and the in_* inputs are ignored that cycle.
- in_valid=0 with stall=0 loads a bubble (out_valid=0, out_instr=0); out_pc still takes in_pc.

Optional Feature:
- Macro: DEC_CLASS_EN.
- When defined, the block adds four 1-bit outputs, combinational from out_instr and gated by out_valid:
  - is_rtype: op==0
  - is_jtype: op==2 or op==3
  - is_load: op in 0x20..0x25
  - is_store: op in 0x28..0x2B
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_instr=0x2008FFFF -> out_valid=0, out_instr=0, out_pc=0, stall_cnt=0.
- Load ADDI: in_instr=0x2008FFFF, in_pc=0x00400000, in_valid=1 -> next cycle op=0x08, rs=0, rt=8, imm_ext=0xFFFFFFFF, out_pc=0x00400000.
- Load ORI: in_instr=0x3508FFFF -> imm_ext=0x0000FFFF.
- Load J: in_instr=0x08000010, in_pc=0x00400000 -> jtarget=0x00000040, index=0x00000010.
- Stall then stall+flush: with a valid instruction held, stall=1 for 3 cycles -> outputs unchanged and stall_cnt=3. Then stall=1 and flush=1 together -> out_valid=0, out_instr=0, stall_cnt stays 3.
- Saturation: build with CNT_W=2, hold stall=1 with out_valid=1 for 5 cycles -> stall_cnt reaches 3 and stays 3.
- With DEC_CLASS_EN: in_instr=0x8C080004 (LW) -> is_load=1 and the other class flags 0; after a flush all class flags are 0.
